// File: rtl/forth_pkg.sv
// Shared definitions for the Forth core boot path: host command bytes and the
// boot loader state encoding.
package forth_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CSUM
    } boot_state_t;

endpackage

// File: rtl/forth_boot_ctrl.sv
// Boot/run controller: parses the host byte stream, loads instruction RAM while
// holding the Forth core in reset, verifies an XOR checksum and releases on RUN.
module forth_boot_ctrl
    import forth_pkg::*;
#(
    parameter int iaddr_width = 10,
    parameter int instr_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   core_reset,
    output logic [iaddr_width-1:0] imem_waddr,
    output logic [instr_width-1:0] imem_wdata,
    output logic                   imem_we,
    output logic                   busy,
    output logic                   err,
    output logic [iaddr_width:0]   words_loaded
);

    localparam logic [iaddr_width:0] DEPTH_W = {1'b1, {iaddr_width{1'b0}}};

    boot_state_t            state_reg, state_next;
    logic                   in_ready_reg;
    logic                   core_reset_reg;
    logic                   err_reg;
    logic [15:0]            count_reg;
    logic [15:0]            word_cnt_reg;
    logic [7:0]             hi_reg;
    logic [7:0]             csum_reg;
    logic                   imem_we_reg;
    logic [iaddr_width-1:0] imem_waddr_reg;
    logic [instr_width-1:0] imem_wdata_reg;
    logic [iaddr_width:0]   words_loaded_reg;

    logic accept;
    logic last_word;
    logic count_zero;
    logic overlength;

    assign accept     = in_valid & in_ready_reg;
    assign last_word  = (word_cnt_reg == count_reg - 16'd1);
    assign count_zero = ({count_reg[15:8], in_data} == 16'd0);
    // Any counter bit above the address range means the word has no RAM slot.
    assign overlength = ((word_cnt_reg >> iaddr_width) != 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (accept) begin
            case (state_reg)
                IDLE:    state_next = (in_data == CMD_LOAD) ? CNT_HI : IDLE;
                CNT_HI:  state_next = CNT_LO;
                CNT_LO:  state_next = count_zero ? CSUM : DATA_HI;
                DATA_HI: state_next = DATA_LO;
                DATA_LO: state_next = last_word ? CSUM : DATA_HI;
                CSUM:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_reg     <= 1'b0;
            core_reset_reg   <= 1'b1;
            err_reg          <= 1'b0;
            count_reg        <= 16'd0;
            word_cnt_reg     <= 16'd0;
            hi_reg           <= 8'd0;
            csum_reg         <= 8'd0;
            imem_we_reg      <= 1'b0;
            imem_waddr_reg   <= '0;
            imem_wdata_reg   <= '0;
            words_loaded_reg <= '0;
        end else begin
            in_ready_reg <= 1'b1;
            imem_we_reg  <= 1'b0;
            if (accept) begin
                case (state_reg)
                    IDLE: begin
                        if (in_data == CMD_LOAD) begin
                            core_reset_reg   <= 1'b1;
                            err_reg          <= 1'b0;
                            words_loaded_reg <= '0;
                            csum_reg         <= 8'd0;
                            word_cnt_reg     <= 16'd0;
                        end else if (in_data == CMD_RUN) begin
                            if (!err_reg) core_reset_reg <= 1'b0;
                        end else if (in_data == CMD_HALT) begin
                            core_reset_reg <= 1'b1;
                        end
                    end
                    CNT_HI: count_reg[15:8] <= in_data;
                    CNT_LO: count_reg[7:0]  <= in_data;
                    DATA_HI: begin
                        hi_reg   <= in_data;
                        csum_reg <= csum_reg ^ in_data;
                    end
                    DATA_LO: begin
                        csum_reg     <= csum_reg ^ in_data;
                        word_cnt_reg <= word_cnt_reg + 16'd1;
                        if (overlength) begin
                            err_reg <= 1'b1;
                        end else begin
                            imem_we_reg    <= 1'b1;
                            imem_waddr_reg <= word_cnt_reg[iaddr_width-1:0];
                            imem_wdata_reg <= {hi_reg, in_data};
                        end
                    end
                    CSUM: begin
                        if (in_data != csum_reg) err_reg <= 1'b1;
                        // Here word_cnt_reg equals count; clamp to RAM depth.
                        words_loaded_reg <= overlength ? DEPTH_W
                                                       : {1'b0, word_cnt_reg[iaddr_width-1:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign core_reset   = core_reset_reg;
    assign err          = err_reg;
    assign imem_we      = imem_we_reg;
    assign imem_waddr   = imem_waddr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_forth_boot_ctrl.sv
// Scoreboard bench for forth_boot_ctrl: a full-size and a 4-word instance share
// one randomized host stream; expected RAM writes are queued per instance.
module tb_forth_boot_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        a_in_ready, a_core_reset, a_we, a_busy, a_err;
    logic [9:0]  a_waddr;
    logic [15:0] a_wdata;
    logic [10:0] a_wl;

    logic        b_in_ready, b_core_reset, b_we, b_busy, b_err;
    logic [1:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [2:0]  b_wl;

    int tests;
    int failed;

    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [15:0] word_q[$];

    bit m_core_reset[2];
    bit m_err[2];
    int m_wl[2];
    int depth[2];

    forth_boot_ctrl #(.iaddr_width(10), .instr_width(16)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .core_reset(a_core_reset), .imem_waddr(a_waddr),
        .imem_wdata(a_wdata), .imem_we(a_we), .busy(a_busy), .err(a_err),
        .words_loaded(a_wl)
    );

    forth_boot_ctrl #(.iaddr_width(2), .instr_width(16)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .core_reset(b_core_reset), .imem_waddr(b_waddr),
        .imem_wdata(b_wdata), .imem_we(b_we), .busy(b_busy), .err(b_err),
        .words_loaded(b_wl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && a_we) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_write", {6'd0, a_waddr, a_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("a_write", {6'd0, a_waddr, a_wdata}, exp_a_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_we) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_write", {14'd0, b_waddr, b_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("b_write", {14'd0, b_waddr, b_wdata}, exp_b_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_core_reset[k] = 1'b1;
            m_err[k]        = 1'b0;
            m_wl[k]         = 0;
        end
    endtask

    task automatic check_status(input string tag, input bit exp_busy);
        check({tag, "_a_core_reset"}, 32'(a_core_reset), 32'(m_core_reset[0]));
        check({tag, "_a_err"},        32'(a_err),        32'(m_err[0]));
        check({tag, "_a_wl"},         32'(a_wl),         32'(m_wl[0]));
        check({tag, "_a_busy"},       32'(a_busy),       32'(exp_busy));
        check({tag, "_b_core_reset"}, 32'(b_core_reset), 32'(m_core_reset[1]));
        check({tag, "_b_err"},        32'(b_err),        32'(m_err[1]));
        check({tag, "_b_wl"},         32'(b_wl),         32'(m_wl[1]));
        check({tag, "_b_busy"},       32'(b_busy),       32'(exp_busy));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_we",       32'({a_we, b_we}), 32'd0);
        check("rst_waddr",    32'(a_waddr), 32'd0);
        check("rst_wdata",    32'(a_wdata), 32'd0);
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'({a_in_ready, b_in_ready}), 32'd3);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit allow_gap);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
        if (allow_gap && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, input string tag);
        send_byte(b, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (b == 8'h02 && !m_err[k]) m_core_reset[k] = 1'b0;
            if (b == 8'h03)              m_core_reset[k] = 1'b1;
        end
        $display("[TB] cmd %s byte=0x%02h core_reset a=%0b b=%0b", tag, b, a_core_reset, b_core_reset);
        check_status(tag, 1'b0);
    endtask

    // Sends a complete LOAD of word_q; expectations come from the frame as a whole.
    task automatic do_load(input bit corrupt, input bit gaps, input string tag);
        int          n;
        logic [7:0]  cs;
        logic [7:0]  cs_sent;
        logic [15:0] w;
        n  = word_q.size();
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            w  = word_q[i];
            cs = cs ^ w[15:8] ^ w[7:0];
            if (i < depth[0]) exp_a_q.push_back({16'(i), w});
            if (i < depth[1]) exp_b_q.push_back({16'(i), w});
        end
        cs_sent = corrupt ? (cs ^ 8'(1 + $urandom_range(0, 254))) : cs;
        send_byte(8'h01, 1'b0);
        check({tag, "_busy_a"}, 32'(a_busy), 32'd1);
        send_byte(8'(n >> 8), gaps);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            w = word_q[i];
            send_byte(w[15:8], gaps);
            send_byte(w[7:0], gaps);
        end
        send_byte(cs_sent, 1'b0);
        for (int k = 0; k < 2; k++) begin
            m_core_reset[k] = 1'b1;
            m_err[k]        = corrupt || (n > depth[k]);
            m_wl[k]         = (n > depth[k]) ? depth[k] : n;
        end
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] load %s words=%0d csum=0x%02h sent=0x%02h err a=%0b b=%0b wl a=%0d b=%0d",
                 tag, n, cs, cs_sent, a_err, b_err, a_wl, b_wl);
        check_status(tag, 1'b0);
        check({tag, "_a_pending"}, 32'(exp_a_q.size()), 32'd0);
        check({tag, "_b_pending"}, 32'(exp_b_q.size()), 32'd0);
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        depth[0] = 1024;
        depth[1] = 4;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        check_status("reset", 1'b0);

        send_cmd(8'h02, "run0");
        send_cmd(8'h03, "halt0");

        word_q = '{16'h1234, 16'hABCD};
        do_load(1'b0, 1'b0, "load2");
        send_cmd(8'h02, "run_ok");

        word_q = '{16'h1234, 16'hABCD};
        do_load(1'b1, 1'b0, "load_bad");
        send_cmd(8'h02, "run_blocked");
        word_q = '{16'h1234, 16'hABCD};
        do_load(1'b0, 1'b0, "load_fix");

        word_q.delete();
        do_load(1'b0, 1'b0, "load0");

        word_q.delete();
        for (int i = 0; i < 5; i++) word_q.push_back(16'($urandom));
        do_load(1'b0, 1'b0, "load5");
        send_cmd(8'h02, "run5");

        for (int it = 0; it < 20; it++) begin
            word_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) word_q.push_back(16'($urandom));
            do_load($urandom_range(0, 3) == 0, 1'b1, $sformatf("rnd%0d", it));
            case ($urandom_range(0, 2))
                0:       send_cmd(8'h02, "rnd_run");
                1:       send_cmd(8'h03, "rnd_halt");
                default: send_cmd(8'(4 + $urandom_range(0, 250)), "rnd_junk");
            endcase
        end

        // Abandon a load right after the first data byte.
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        check("midload_busy", 32'({a_busy, b_busy}), 32'd3);
        do_reset();
        check_status("midload_reset", 1'b0);
        send_cmd(8'h02, "run_after_reset");
        repeat (3) @(posedge clk);
        #1;
        check("final_a_pending", 32'(exp_a_q.size()), 32'd0);
        check("final_b_pending", 32'(exp_b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
